sm83_seq_engine: RTL and testbench

Parametrised micro-step sequencer for the SM83 core. It replaces the fixed six-step control walker. It steps through a decoder-supplied sequence of execute states and selects a taken or not-taken end step from a registered condition. It also adds a memory stall handshake, a HALT state with wake-up, and interrupt dispatch as a built-in five-step sequence. It sits between the opcode decoder and the control-strobe decode, and owns the fetch and IR-load boundary.

---
 rtl/sm83_seq_engine.sv | 162 ++++++++++++++++
 tb/tb_sm83_seq_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_seq_engine.sv
// sm83_seq_engine: micro-step sequencer with stall, HALT and IRQ dispatch.
// Walks decoder-supplied execute states and owns the fetch boundary.
module sm83_seq_engine #(
  parameter int MAX_STEPS = 8,
  parameter int STATE_W = 6,
  parameter int NUM_IRQ = 5,
  parameter logic [STATE_W-1:0] DISP_BASE = 6'h30,
  localparam int IDX_W = $clog2(MAX_STEPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAX_STEPS*STATE_W-1:0] seq_steps,
  input  logic [IDX_W-1:0]             last_taken,
  input  logic [IDX_W-1:0]             last_not_taken,
  input  logic                         cond_eval,
  input  logic                         cond_true,
  input  logic                         halt_req,
  input  logic                         stall,
  input  logic                         ime,
  input  logic [NUM_IRQ-1:0]           irq_req,
  output logic [STATE_W-1:0]           cur_state,
  output logic [IDX_W-1:0]             step,
  output logic [1:0]                   mode,
  output logic                         step_en,
  output logic                         last,
  output logic                         fetch,
  output logic                         taken,
  output logic                         halted,
  output logic                         ime_clr,
  output logic [NUM_IRQ-1:0]           irq_ack,
  output logic [7:0]                   irq_vec
);

  // Dispatch needs steps 0..4 even when IDX_W is narrower.
  localparam int CW = (IDX_W > 3) ? IDX_W : 3;

  typedef enum logic [1:0] {
    M_RUN  = 2'b00,
    M_HALT = 2'b01,
    M_DISP = 2'b10
  } mode_e;

  mode_e            r_mode;
  logic [CW-1:0]    r_step;
  logic             r_taken;
  logic [7:0]       r_vec;

  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_end;
  logic [STATE_W-1:0] w_slot;
  logic               w_last_run;
  logic               w_go;
  logic               w_irq;
  logic               w_bnd;
  logic               w_d3;
  logic               w_d4;
  logic [NUM_IRQ-1:0] w_onehot;
  logic [7:0]         w_vec;

  assign w_idx  = r_step[IDX_W-1:0];
  assign w_slot = seq_steps[w_idx*STATE_W +: STATE_W];
  assign w_end  = r_taken ? last_taken : last_not_taken;
  assign w_last_run = (w_idx >= w_end) ||
                      (w_idx == IDX_W'(MAX_STEPS-1));
  assign w_go   = !stall && !rst;
  assign w_irq  = |irq_req;
  assign w_bnd  = (r_mode == M_RUN) && w_last_run && w_go;
  assign w_d3   = (r_mode == M_DISP) && (r_step == CW'(3));
  assign w_d4   = (r_mode == M_DISP) && (r_step == CW'(4));
  assign w_onehot = irq_req & (~irq_req + NUM_IRQ'(1));

  always_comb begin
    w_vec = 8'h00;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (irq_req[i]) w_vec = 8'h40 + 8'(i*8);
    end
  end

  assign step   = w_idx;
  assign mode   = r_mode;
  assign taken  = r_taken;
  assign halted = (r_mode == M_HALT);

  always_comb begin
    cur_state = w_slot;
    step_en   = 1'b0;
    last      = 1'b0;
    fetch     = 1'b0;
    ime_clr   = 1'b0;
    irq_ack   = '0;
    irq_vec   = 8'h00;
    unique case (r_mode)
      M_RUN: begin
        step_en = w_go;
        last    = w_last_run;
        if (w_bnd && !halt_req) begin
          if (ime && w_irq) ime_clr = 1'b1;
          else fetch = 1'b1;
        end
      end
      M_HALT: begin
        cur_state = seq_steps[STATE_W-1:0];
        if (w_go && w_irq) begin
          if (ime) ime_clr = 1'b1;
          else fetch = 1'b1;
        end
      end
      M_DISP: begin
        cur_state = DISP_BASE + STATE_W'(r_step);
        step_en   = w_go;
        last      = w_d4;
        if (w_d3) begin
          irq_vec = w_vec;
          if (w_go) irq_ack = w_onehot;
        end
        if (w_d4) begin
          irq_vec = r_vec;
          fetch   = w_go;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= M_RUN;
      r_step  <= '0;
      r_taken <= 1'b1;
      r_vec   <= 8'h00;
    end else if (!stall) begin
      unique case (r_mode)
        M_RUN: begin
          if (cond_eval) r_taken <= cond_true;
          if (w_last_run) begin
            r_step  <= '0;
            r_taken <= 1'b1;
            if (halt_req) r_mode <= M_HALT;
            else if (ime && w_irq) r_mode <= M_DISP;
          end else begin
            r_step <= r_step + CW'(1);
          end
        end
        M_HALT: begin
          r_step <= '0;
          if (w_irq) r_mode <= ime ? M_DISP : M_RUN;
        end
        M_DISP: begin
          if (w_d3) r_vec <= w_vec;
          if (w_d4) begin
            r_mode <= M_RUN;
            r_step <= '0;
          end else begin
            r_step <= r_step + CW'(1);
          end
        end
        default: r_mode <= M_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_seq_engine.sv
// tb_sm83_seq_engine: directed and random checks of the sequencer
// against a cycle-level behavioural model.
module tb_sm83_seq_engine;
  localparam int MS = 8;
  localparam int SW = 6;
  localparam int NI = 5;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [MS*SW-1:0] seq;
  logic [IW-1:0] lt, lnt;
  logic ce, ct, hr, st, ime;
  logic [NI-1:0] irq;

  logic [SW-1:0] cs;
  logic [IW-1:0] stp;
  logic [1:0] md;
  logic sen, lst, fch, tkn, hlt, imc;
  logic [NI-1:0] ack;
  logic [7:0] vec;

  logic [16*SW-1:0] seq16;
  logic [3:0] lt16, stp16;
  logic [SW-1:0] cs16;
  logic [1:0] md16;
  logic sen16, lst16, fch16, tkn16, hlt16, imc16;
  logic [NI-1:0] ack16;
  logic [7:0] vec16;

  logic [12*SW-1:0] seq12;
  logic [3:0] lt12, stp12;
  logic [SW-1:0] cs12;
  logic [1:0] md12;
  logic sen12, lst12, fch12, tkn12, hlt12, imc12;
  logic [NI-1:0] ack12;
  logic [7:0] vec12;

  always #5 clk = ~clk;

  sm83_seq_engine u8d (
    .clk(clk), .rst(rst), .seq_steps(seq),
    .last_taken(lt), .last_not_taken(lnt),
    .cond_eval(ce), .cond_true(ct), .halt_req(hr),
    .stall(st), .ime(ime), .irq_req(irq),
    .cur_state(cs), .step(stp), .mode(md),
    .step_en(sen), .last(lst), .fetch(fch),
    .taken(tkn), .halted(hlt), .ime_clr(imc),
    .irq_ack(ack), .irq_vec(vec)
  );

  sm83_seq_engine #(.MAX_STEPS(16)) u16d (
    .clk(clk), .rst(rst), .seq_steps(seq16),
    .last_taken(lt16), .last_not_taken(lt16),
    .cond_eval(1'b0), .cond_true(1'b0), .halt_req(1'b0),
    .stall(1'b0), .ime(1'b0), .irq_req(5'b0),
    .cur_state(cs16), .step(stp16), .mode(md16),
    .step_en(sen16), .last(lst16), .fetch(fch16),
    .taken(tkn16), .halted(hlt16), .ime_clr(imc16),
    .irq_ack(ack16), .irq_vec(vec16)
  );

  sm83_seq_engine #(.MAX_STEPS(12)) u12d (
    .clk(clk), .rst(rst), .seq_steps(seq12),
    .last_taken(lt12), .last_not_taken(lt12),
    .cond_eval(1'b0), .cond_true(1'b0), .halt_req(1'b0),
    .stall(1'b0), .ime(1'b0), .irq_req(5'b0),
    .cur_state(cs12), .step(stp12), .mode(md12),
    .step_en(sen12), .last(lst12), .fetch(fch12),
    .taken(tkn12), .halted(hlt12), .ime_clr(imc12),
    .irq_ack(ack12), .irq_vec(vec12)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Model state: mode 0 run, 1 halt, 2 dispatch.
  int m_mode, m_step, m_taken;
  int m_vec;

  logic s_fetch, s_clr, s_en, s_fch16, s_fch12;
  logic [IW-1:0] s_step;
  logic [1:0] s_mode;
  logic [NI-1:0] s_ack;
  logic [7:0] s_vec;
  logic [3:0] s_stp16, s_stp12;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    int e_state, e_en, e_last, e_fetch, e_clr, e_ack, e_vec;
    int endi, low;
    @(negedge clk);
    low = -1;
    for (int i = NI-1; i >= 0; i--) if (irq[i]) low = i;
    e_en = 0; e_last = 0; e_fetch = 0; e_clr = 0;
    e_ack = 0; e_vec = 0; e_state = 0;
    case (m_mode)
      0: begin
        e_state = seq[m_step*SW +: SW];
        endi = m_taken ? lt : lnt;
        e_last = (m_step >= endi) || (m_step == MS-1);
        e_en = !st;
        if (e_last && !st && !hr) begin
          if (ime && low >= 0) e_clr = 1;
          else e_fetch = 1;
        end
      end
      1: begin
        e_state = seq[SW-1:0];
        if (!st && low >= 0) begin
          if (ime) e_clr = 1;
          else e_fetch = 1;
        end
      end
      default: begin
        e_state = 'h30 + m_step;
        e_en = !st;
        e_last = (m_step == 4);
        if (m_step == 3 && low >= 0) begin
          e_vec = 'h40 + 8*low;
          if (!st) e_ack = 1 << low;
        end
        if (m_step == 4) begin
          e_vec = m_vec;
          e_fetch = !st;
        end
      end
    endcase
    if (rst) begin
      e_en = 0; e_fetch = 0; e_clr = 0; e_ack = 0;
    end
    chk({tag, ".state"}, cs, e_state);
    chk({tag, ".step"}, stp, m_step);
    chk({tag, ".mode"}, md, m_mode);
    chk({tag, ".step_en"}, sen, e_en);
    chk({tag, ".last"}, lst, e_last);
    chk({tag, ".fetch"}, fch, e_fetch);
    chk({tag, ".taken"}, tkn, m_taken);
    chk({tag, ".halted"}, hlt, m_mode == 1);
    chk({tag, ".ime_clr"}, imc, e_clr);
    chk({tag, ".irq_ack"}, ack, e_ack);
    chk({tag, ".irq_vec"}, vec, e_vec);
    s_fetch = fch; s_clr = imc; s_en = sen; s_step = stp;
    s_mode = md; s_ack = ack; s_vec = vec;
    s_fch16 = fch16; s_stp16 = stp16;
    s_fch12 = fch12; s_stp12 = stp12;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_step = 0; m_taken = 1; m_vec = 0;
    end else if (!st) begin
      case (m_mode)
        0: begin
          if (ce) m_taken = ct;
          if (e_last) begin
            m_step = 0; m_taken = 1;
            if (hr) m_mode = 1;
            else if (ime && low >= 0) m_mode = 2;
          end else m_step++;
        end
        1: if (low >= 0) m_mode = ime ? 2 : 0;
        default: begin
          if (m_step == 3) m_vec = e_vec;
          if (m_step == 4) begin
            m_mode = 0; m_step = 0;
          end else m_step++;
        end
      endcase
    end
    #1;
  endtask

  task automatic run_jp(input bit c, output int n, output int fs);
    n = 0; fs = -1;
    for (int k = 0; k < 20; k++) begin
      ce = (stp == 1); ct = c;
      cyc("jp");
      n++;
      if (s_fetch) begin
        fs = s_step;
        break;
      end
    end
    ce = 0;
  endtask

  initial begin
    int n, fs, scnt, fcnt, bad;
    rst = 1; ce = 0; ct = 0; hr = 0; st = 0; ime = 0; irq = '0;
    lt = 3; lnt = 2;
    for (int i = 0; i < MS; i++) seq[i*SW +: SW] = SW'($urandom);
    for (int i = 0; i < 16; i++) seq16[i*SW +: SW] = SW'($urandom);
    for (int i = 0; i < 12; i++) seq12[i*SW +: SW] = SW'($urandom);
    lt16 = 15; lt12 = 15;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 0; m_step = 0; m_taken = 1; m_vec = 0;
    chk("rst.mode", md, 0);
    chk("rst.step", stp, 0);
    chk("rst.taken", tkn, 1);
    chk("rst.ack", ack, 0);
    rst = 0;

    run_jp(1'b1, n, fs);
    chk("jp_t.cycles", n, 4);
    chk("jp_t.fstep", fs, 3);
    run_jp(1'b0, n, fs);
    chk("jp_nt.cycles", n, 3);
    chk("jp_nt.fstep", fs, 2);
    chk("jp_nt.taken_after", tkn, 1);

    lt = 3; lnt = 3; scnt = 0; fcnt = 0; n = 0;
    for (int k = 0; k < 20; k++) begin
      st = (stp == 1 && scnt < 2);
      if (st) scnt++;
      cyc("stall");
      n++;
      if (st) begin
        chk("stall.step_held", s_step, 1);
        chk("stall.step_en", s_en, 0);
      end
      if (s_fetch) begin
        fcnt++;
        break;
      end
    end
    st = 0;
    chk("stall.cycles", n, 6);
    chk("stall.fetches", fcnt, 1);

    lt = 0; lnt = 0; ime = 1; irq = 5'b10100;
    cyc("bnd");
    chk("bnd.ime_clr", s_clr, 1);
    chk("bnd.fetch", s_fetch, 0);
    ime = 0;
    for (int d = 0; d < 5; d++) begin
      cyc("disp");
      chk("disp.step", s_step, d);
      chk("disp.mode", s_mode, 2);
      if (d == 3) begin
        chk("disp.ack", s_ack, 5'b00100);
        chk("disp.vec3", s_vec, 8'h50);
      end
      if (d == 4) begin
        chk("disp.fetch", s_fetch, 1);
        chk("disp.vec4", s_vec, 8'h50);
      end
    end
    chk("disp.back_run", md, 0);
    irq = '0;

    lt = 1; lnt = 1;
    for (int k = 0; k < 2; k++) begin
      hr = (stp == 1);
      cyc("halt_in");
      chk("halt_in.nofetch", s_fetch, 0);
    end
    hr = 0;
    chk("halt.halted", hlt, 1);
    repeat (2) begin
      cyc("halt_idle");
      chk("halt_idle.nofetch", s_fetch, 0);
    end
    irq = 5'b00001; ime = 0;
    cyc("wake0");
    chk("wake0.fetch", s_fetch, 1);
    chk("wake0.run", md, 0);
    irq = '0;
    for (int k = 0; k < 2; k++) begin
      hr = (stp == 1);
      cyc("halt_in2");
    end
    hr = 0;
    chk("halt2.halted", hlt, 1);
    irq = 5'b00001; ime = 1;
    cyc("wake1");
    chk("wake1.ime_clr", s_clr, 1);
    ime = 0;
    for (int d = 0; d < 5; d++) begin
      cyc("wdisp");
      if (d == 3) chk("wdisp.vec", s_vec, 8'h40);
    end
    irq = '0;

    lt = 0; lnt = 0; ime = 1; irq = 5'b00010;
    cyc("rbnd");
    ime = 0;
    cyc("rd0");
    cyc("rd1");
    chk("rd2.step", stp, 2);
    rst = 1;
    cyc("rd2_rst");
    chk("rd2_rst.ack", s_ack, 0);
    chk("rd2_rst.fetch", s_fetch, 0);
    rst = 0;
    chk("after_rst.mode", md, 0);
    chk("after_rst.step", stp, 0);
    chk("after_rst.taken", tkn, 1);
    chk("after_rst.ack", ack, 0);
    irq = '0;

    rst = 1; cyc("r16"); rst = 0;
    n = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      cyc("w16");
      if (s_stp16 != 4'(n)) bad++;
      n++;
      if (s_fch16) break;
    end
    chk("w16.cycles", n, 16);
    chk("w16.order", bad, 0);

    rst = 1; cyc("r12"); rst = 0;
    n = 0; fs = -1;
    for (int k = 0; k < 40; k++) begin
      cyc("w12");
      n++;
      if (s_fch12) begin
        fs = s_stp12;
        break;
      end
    end
    chk("sat12.cycles", n, 12);
    chk("sat12.fstep", fs, 11);

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < MS; i++) seq[i*SW +: SW] = SW'($urandom);
      lt = IW'($urandom); lnt = IW'($urandom);
      ce = ($urandom_range(3) == 0); ct = 1'($urandom);
      hr = ($urandom_range(9) == 0);
      st = ($urandom_range(3) == 0);
      ime = 1'($urandom);
      irq = ($urandom_range(4) == 0) ? NI'($urandom) : '0;
      rst = ($urandom_range(49) == 0);
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
